// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared status types and helpers for the pulse interface blocks
package pulse_pkg;

    typedef struct packed {
        logic overflow;
        logic stretch_err;
    } pulse_status_t;

    localparam pulse_status_t STATUS_CLEAR = '{overflow: 1'b0, stretch_err: 1'b0};

    // Sticky update: a set event in the same cycle as a clear keeps the flag at 1.
    function automatic pulse_status_t update_status(
        input pulse_status_t cur,
        input pulse_status_t set,
        input logic          clr
    );
        pulse_status_t nxt;
        nxt.overflow    = set.overflow    | (cur.overflow    & ~clr);
        nxt.stretch_err = set.stretch_err | (cur.stretch_err & ~clr);
        return nxt;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO with occupancy count
module sync_fifo #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [N-1:0]             push_data,
    input  logic                     pop,
    output logic [N-1:0]             pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [N-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pulse_capture.sv
// rtl/pulse_capture.sv - one-cycle pulse detector feeding a valid/ready FIFO with sticky faults
module pulse_capture
    import pulse_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N-1:0]             pulse_in,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [N-1:0]             out_data,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     clear_err,
    output logic                     overflow,
    output logic                     stretch_err
);
    logic          nz;
    logic          prev_nz;
    logic          capture;
    logic          stretch;
    logic          pop;
    logic          push;
    logic          full;
    logic          empty;
    pulse_status_t status;
    pulse_status_t status_set;

    assign nz      = |pulse_in;
    assign capture = nz & ~prev_nz;
    assign stretch = nz & prev_nz;

    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;

    // A full FIFO still accepts a pulse when the head leaves in the same cycle.
    assign push = capture & (~full | pop);

    assign status_set.overflow    = capture & full & ~pop;
    assign status_set.stretch_err = stretch;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_nz <= 1'b0;
            status  <= STATUS_CLEAR;
        end else begin
            prev_nz <= nz;
            status  <= update_status(status, status_set, clear_err);
        end
    end

    assign overflow    = status.overflow;
    assign stretch_err = status.stretch_err;

    sync_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (pulse_in),
        .pop       (pop),
        .pop_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_pulse_capture.sv
// tb/tb_pulse_capture.sv - directed and randomized scoreboard bench for pulse_capture
module tb_pulse_capture;
    localparam int N     = 8;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] pulse_in;
    logic         out_ready;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic [2:0]   count;
    logic         clear_err;
    logic         overflow;
    logic         stretch_err;

    logic [N-1:0] sb_q[$];
    logic         m_prev;
    logic         m_ovf;
    logic         m_str;
    int           n_chk  = 0;
    int           n_pass = 0;
    int           n_push = 0;

    always #5 clk = ~clk;

    pulse_capture #(.N(N), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .pulse_in    (pulse_in),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .count       (count),
        .clear_err   (clear_err),
        .overflow    (overflow),
        .stretch_err (stretch_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Drive one cycle, advance the model, then compare the post-edge state.
    task automatic cyc(input logic [N-1:0] p, input logic rdy, input logic clr, input logic rst);
        logic         nz, cap, pop, full, set_o, set_s;
        logic [N-1:0] e;
        pulse_in  = p;
        out_ready = rdy;
        clear_err = clr;
        reset     = rst;
        nz = |p;
        if (rst) begin
            sb_q.delete();
            m_prev = 1'b0;
            m_ovf  = 1'b0;
            m_str  = 1'b0;
        end else begin
            pop   = (sb_q.size() != 0) && rdy;
            full  = (sb_q.size() == DEPTH);
            cap   = nz && !m_prev;
            set_s = nz && m_prev;
            set_o = cap && full && !pop;
            if (pop) begin
                chk("pop_data", out_data, sb_q[0]);
                void'(sb_q.pop_front());
            end
            if (cap && !set_o) begin
                sb_q.push_back(p);
                n_push++;
            end
            m_ovf  = set_o | (m_ovf & ~clr);
            m_str  = set_s | (m_str & ~clr);
            m_prev = nz;
        end
        @(posedge clk);
        #1;
        e = (sb_q.size() != 0) ? sb_q[0] : '0;
        chk("count", count, sb_q.size());
        chk("out_valid", out_valid, sb_q.size() != 0);
        chk("out_data", out_data, e);
        chk("overflow", overflow, m_ovf);
        chk("stretch_err", stretch_err, m_str);
    endtask

    initial begin
        logic [N-1:0] rp;
        logic         last_nz;

        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_count", count, 3'd0);

        // single pulse latency and pop
        cyc(8'h5A, 1'b0, 1'b0, 1'b0);
        chk("t1_data", out_data, 8'h5A);
        chk("t1_count", count, 3'd1);
        cyc(8'h00, 1'b1, 1'b0, 1'b0);
        chk("t1_pop_valid", out_valid, 1'b0);
        chk("t1_pop_data", out_data, 8'h00);

        // fill to four and drain in order
        for (int i = 1; i <= 4; i++) begin
            cyc(N'(i), 1'b0, 1'b0, 1'b0);
            cyc(8'h00, 1'b0, 1'b0, 1'b0);
        end
        chk("t2_count", count, 3'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("t2_order", out_data, i);
            cyc(8'h00, 1'b1, 1'b0, 1'b0);
        end

        // drop on full, then accept with simultaneous pop
        for (int i = 0; i < 4; i++) begin
            cyc(8'hA1 + N'(i), 1'b0, 1'b0, 1'b0);
            cyc(8'h00, 1'b0, 1'b0, 1'b0);
        end
        cyc(8'hFF, 1'b0, 1'b0, 1'b0);
        chk("t3_ovf", overflow, 1'b1);
        chk("t3_count", count, 3'd4);
        chk("t3_head", out_data, 8'hA1);
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        cyc(8'hFF, 1'b1, 1'b0, 1'b0);
        chk("t3_acc_count", count, 3'd4);
        chk("t3_acc_ovf", overflow, 1'b1);
        for (int i = 0; i < 3; i++) cyc(8'h00, 1'b1, 1'b0, 1'b0);
        chk("t3_tail", out_data, 8'hFF);
        cyc(8'h00, 1'b1, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b1, 1'b0);
        chk("t3_clr", overflow, 1'b0);

        // stretched pulse and clear/set priority
        for (int i = 0; i < 3; i++) cyc(8'h33, 1'b0, 1'b0, 1'b0);
        chk("t4_count", count, 3'd1);
        chk("t4_data", out_data, 8'h33);
        chk("t4_str", stretch_err, 1'b1);
        cyc(8'h00, 1'b1, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b1, 1'b0);
        chk("t4_clr", stretch_err, 1'b0);
        cyc(8'h44, 1'b0, 1'b0, 1'b0);
        cyc(8'h44, 1'b0, 1'b1, 1'b0);
        chk("t4_set_wins", stretch_err, 1'b1);
        cyc(8'h00, 1'b1, 1'b1, 1'b0);

        // reset mid-operation with a coincident pulse
        for (int i = 1; i <= 3; i++) begin
            cyc(N'(i), 1'b0, 1'b0, 1'b0);
            cyc(8'h00, 1'b0, 1'b0, 1'b0);
        end
        chk("t5_pre_count", count, 3'd3);
        cyc(8'h77, 1'b0, 1'b0, 1'b1);
        chk("t5_count", count, 3'd0);
        chk("t5_valid", out_valid, 1'b0);
        chk("t5_flags", {overflow, stretch_err}, 2'b00);
        cyc(8'h10, 1'b0, 1'b0, 1'b0);
        chk("t5_data", out_data, 8'h10);
        cyc(8'h00, 1'b1, 1'b0, 1'b0);

        // randomized traffic against the scoreboard
        n_push  = 0;
        last_nz = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            rp = '0;
            if (!last_nz && ($urandom_range(0, 1) == 1)) rp = N'($urandom_range(1, 255));
            last_nz = |rp;
            cyc(rp, 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0), 1'b0);
        end
        chk("t6_wraps", n_push >= 4 * 100, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
